// File: rtl/uart_receiver_if.sv
// uart_receiver_if: valid/ready byte stream from the UART receive FIFO to its consumer
//   master drives rx_data/rx_valid and samples rx_ready; slave is the consumer side
interface uart_receiver_if #(
  parameter int DataWidth = 8
);
  logic [DataWidth-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver with glitch-filtered start detection and a valid/ready FIFO
//   clk, rst_n   clock, asynchronous active-low reset
//   rx           serial input, idle high, asynchronous to clk
//   rx_if        master side of uart_receiver_if: rx_data/rx_valid out (FIFO head), rx_ready in
//   fifo_count   bytes held, 0..FIFO_DEPTH
//   busy         frame in progress
//   frame_err / overrun_err / parity_err   1-clk error pulses
//   RX_PARITY_EN define to expect one even-parity bit after the data bits
module uart_receiver #(
  parameter int BAUD       = 9600,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int StopBits   = 2,
  parameter int DataWidth  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  uart_receiver_if.master               rx_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          parity_err
);
  localparam int TICK_LIMIT = CLK_FREQ / (BAUD * 16);
  localparam int TW = $clog2(TICK_LIMIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2((DataWidth > StopBits ? DataWidth : StopBits) + 1);
  localparam logic [BW-1:0] LAST_D = BW'(DataWidth - 1);
  localparam logic [BW-1:0] LAST_S = BW'(StopBits - 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx_s, rx_prev, tick, sample, done, push, perr_q;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           s_cnt, s_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DataWidth-1:0] shreg, shreg_n;
  logic                 stop_bad, stop_bad_n, par_bad, par_bad_n;
  logic [DataWidth-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 pop, full, wr_en;
  logic [CW-1:0]        count_n;
  assign rx_s   = sync[1];
  assign tick   = tick_cnt == TW'(TICK_LIMIT - 1);
  assign sample = tick && s_cnt == 4'd15;
  assign busy   = state != S_IDLE;
`ifdef RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
  always_comb begin
    state_n    = state;
    s_cnt_n    = (tick && state != S_IDLE) ? s_cnt + 4'd1 : s_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    stop_bad_n = stop_bad;
    par_bad_n  = par_bad;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        s_cnt_n    = '0;
        bit_cnt_n  = '0;
        stop_bad_n = 1'b0;
        par_bad_n  = 1'b0;
        // only a 1->0 edge starts a frame, so a line held low cannot retrigger
        if (rx_prev && !rx_s) state_n = S_START;
      end
      S_START: if (tick && s_cnt == 4'd7) begin
        s_cnt_n = '0;
        state_n = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: if (sample) begin
        shreg_n   = {rx_s, shreg[DataWidth-1:1]};
        bit_cnt_n = (bit_cnt == LAST_D) ? '0 : bit_cnt + 1'b1;
`ifdef RX_PARITY_EN
        if (bit_cnt == LAST_D) state_n = S_PARITY;
`else
        if (bit_cnt == LAST_D) state_n = S_STOP;
`endif
      end
`ifdef RX_PARITY_EN
      S_PARITY: if (sample) begin
        par_bad_n = rx_s ^ (^shreg);
        state_n   = S_STOP;
      end
`endif
      S_STOP: if (sample) begin
        stop_bad_n = stop_bad | ~rx_s;
        bit_cnt_n  = bit_cnt + 1'b1;
        if (bit_cnt == LAST_S) begin
          state_n = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      state     <= S_IDLE;
      tick_cnt  <= '0;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_bad  <= 1'b0;
      par_bad   <= 1'b0;
      push      <= 1'b0;
      frame_err <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rx_prev   <= rx_s;
      state     <= state_n;
      tick_cnt  <= (state == S_IDLE || tick) ? '0 : tick_cnt + 1'b1;
      s_cnt     <= s_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      stop_bad  <= stop_bad_n;
      par_bad   <= par_bad_n;
      // verdict on the completed frame uses the final stop sample directly
      push      <= done && rx_s && !stop_bad && !par_bad;
      frame_err <= done && (!rx_s || stop_bad);
      perr_q    <= done && par_bad;
    end
  assign pop     = rx_if.rx_valid && rx_if.rx_ready;
  assign full    = fifo_count == CW'(FIFO_DEPTH);
  assign wr_en   = push && (!full || pop);
  assign count_n = fifo_count + CW'(wr_en) - CW'(pop);
  assign rx_if.rx_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      rx_if.rx_valid <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      if (wr_en) mem[wr_ptr] <= shreg;
      wr_ptr         <= wr_ptr + AW'(wr_en);
      rd_ptr         <= rd_ptr + AW'(pop);
      fifo_count     <= count_n;
      rx_if.rx_valid <= count_n != '0;
      overrun_err    <= push && full && !pop;
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames checked against a queue model of the receive FIFO
module tb_uart_receiver;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int SB       = 2;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [2:0] fifo_count;
  logic busy, frame_err, overrun_err, parity_err;
  int n_checks = 0, n_fail = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, valid_cyc = 0;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  uart_receiver_if #(.DataWidth(DW)) bus ();
  uart_receiver #(
    .BAUD(BAUD), .CLK_FREQ(CLK_FREQ), .StopBits(SB), .DataWidth(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_if(bus), .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    fe_cnt += int'(frame_err);
    ov_cnt += int'(overrun_err);
    pe_cnt += int'(parity_err);
    valid_cyc += int'(bus.rx_valid);
    check("valid_vs_count", bus.rx_valid, fifo_count != 3'd0);
    if (bus.rx_valid) begin
      check("head_present", q.size() != 0, 1'b1);
      if (q.size() != 0) check("head", bus.rx_data, q[0]);
      if (bus.rx_ready) begin
        popped.push_back(bus.rx_data);
        if (q.size() != 0) void'(q.pop_front());
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par);
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      cyc(BIT);
      if (i == 0) check("busy_mid", busy, 1'b1);
    end
`ifdef RX_PARITY_EN
    rx = (^d) ^ bad_par;
    cyc(BIT);
`endif
    for (int s = 0; s < SB; s++) begin
      rx = !(bad_stop && s == 0);
      cyc(BIT);
    end
    rx = 1'b1;
  endtask
  task automatic run_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par, input bit ready);
    bit exp_ov;
    bus.rx_ready = ready;
    fe_cnt = 0;
    ov_cnt = 0;
    pe_cnt = 0;
    exp_ov = 1'b0;
    if (!bad_stop && !bad_par) begin
      if (!ready && q.size() == DEPTH) exp_ov = 1'b1;
      else q.push_back(d);
    end
    send_frame(d, bad_stop, bad_par);
    cyc(3 * BIT);
    check("frame_err_pulses", fe_cnt, bad_stop);
    check("parity_err_pulses", pe_cnt, bad_par);
    check("overrun_pulses", ov_cnt, exp_ov);
    check("busy_idle", busy, 1'b0);
    check("fifo_count", fifo_count, q.size());
  endtask
  initial begin
    bus.rx_ready = 1'b0;
    cyc(3);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_data", bus.rx_data, 8'h00);
    check("rst_count", fifo_count, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {frame_err, overrun_err, parity_err}, 3'b000);
    rst_n = 1'b1;
    cyc(BIT);
    valid_cyc = 0;
    popped.delete();
    run_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("t1_valid_cycles", valid_cyc, 1);
    check("t1_pops", popped.size(), 1);
    check("t1_data", popped.size() == 1 ? popped[0] : 8'h00, 8'hA5);
    fe_cnt = 0;
    ov_cnt = 0;
    pe_cnt = 0;
    rx = 1'b0;
    cyc(20);
    check("glitch_busy", busy, 1'b1);
    cyc(30);
    rx = 1'b1;
    cyc(3 * BIT);
    check("glitch_busy_after", busy, 1'b0);
    check("glitch_count", fifo_count, 3'd0);
    check("glitch_errs", fe_cnt + ov_cnt + pe_cnt, 0);
    run_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    check("t3_count", fifo_count, 3'd0);
    popped.delete();
    for (int i = 1; i <= 5; i++) run_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check("t4_count", fifo_count, 3'd4);
    check("t4_overrun_on_5th", ov_cnt, 1);
    bus.rx_ready = 1'b1;
    cyc(10);
    check("t4_drain_n", popped.size(), 4);
    for (int i = 0; i < popped.size(); i++) check("t4_drain", popped[i], 8'(i + 1));
    run_frame(8'h33, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    cyc(BIT);
    rx = 1'b1;
    cyc(3 * BIT);
    rst_n = 1'b0;
    #2;
    q.delete();
    check("t5_valid", bus.rx_valid, 1'b0);
    check("t5_data", bus.rx_data, 8'h00);
    check("t5_count", fifo_count, 3'd0);
    check("t5_busy", busy, 1'b0);
    check("t5_errs", {frame_err, overrun_err, parity_err}, 3'b000);
    cyc(5);
    rst_n = 1'b1;
    cyc(BIT);
    popped.delete();
    run_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("t5_data_after", popped.size() == 1 ? popped[0] : 8'h00, 8'h5A);
    fe_cnt = 0;
    rx = 1'b0;
    cyc(13 * BIT);
    check("break_fe", fe_cnt, 1);
    check("break_busy", busy, 1'b0);
    check("break_count", fifo_count, 3'd0);
    rx = 1'b1;
    cyc(3 * BIT);
    check("break_fe_once", fe_cnt, 1);
`ifdef RX_PARITY_EN
    popped.delete();
    run_frame(8'h07, 1'b0, 1'b1, 1'b1);
    check("t6_no_push", popped.size(), 0);
    run_frame(8'h07, 1'b0, 1'b0, 1'b1);
    check("t6_data", popped.size() == 1 ? popped[0] : 8'h00, 8'h07);
`endif
    for (int n = 0; n < 14; n++) begin
      bit bs, bp;
      bs = $urandom_range(0, 4) == 0;
`ifdef RX_PARITY_EN
      bp = $urandom_range(0, 4) == 0;
`else
      bp = 1'b0;
`endif
      run_frame(8'($urandom), bs, bp, 1'($urandom_range(0, 1)));
    end
    bus.rx_ready = 1'b1;
    cyc(20);
    check("final_model_empty", q.size(), 0);
    check("final_count", fifo_count, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
